// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: fetch/exec/writeback sequencer driving a 4-bit ADD/NAND ALU with a 4x4 register file
module alu_seq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  output logic       imem_req,
  output logic [3:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_sel,
  input  logic [3:0] alu_res,
  output logic [3:0] pc,
  output logic       halted,
  input  logic [1:0] dbg_sel,
  output logic [3:0] dbg_data
);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WB, HALT} state_t;
  state_t     state;
  logic [7:0] ir;
  logic [3:0] rf [4];
  logic [1:0] op, rd, rs;
  assign op        = ir[7:6];
  assign rd        = ir[5:4];
  assign rs        = ir[3:2];
  assign imem_addr = pc;
  assign dbg_data  = rf[dbg_sel];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= 4'h0;
      ir       <= 8'h00;
      alu_a    <= 4'h0;
      alu_b    <= 4'h0;
      alu_sel  <= 1'b0;
      imem_req <= 1'b0;
      halted   <= 1'b0;
      for (int i = 0; i < 4; i++) rf[i] <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: if (imem_ack) begin
          ir       <= imem_data;
          state    <= EXEC;
          imem_req <= 1'b0;
        end
        EXEC: if (op == 2'b11) begin
          state  <= HALT;
          halted <= 1'b1;
        end else begin
          // operands stay frozen through WB so the ALU has a full cycle to settle
          if (!op[1]) begin
            alu_a   <= rf[rd];
            alu_b   <= rf[rs];
            alu_sel <= op[0];
          end
          state <= WB;
        end
        WB: begin
          rf[rd]   <= op[1] ? ir[3:0] : alu_res;
          pc       <= pc + 4'h1;
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: table-driven program run with scoreboard of register writebacks plus fetch-wait, halt, wrap and mid-WB reset sequences
`timescale 1ns/1ps
module tb_alu_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       imem_ack = 1'b0;
  logic [7:0] imem_data = 8'h00;
  logic [1:0] dbg_sel = 2'd0;
  logic       imem_req, alu_sel, halted;
  logic [3:0] imem_addr, alu_a, alu_b, alu_res, pc, dbg_data;

  alu_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sel(alu_sel), .alu_res(alu_res), .pc(pc), .halted(halted),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #25 clk = ~clk;
  assign alu_res = alu_sel ? ~(alu_a & alu_b) : alu_a + alu_b;

  typedef struct {
    logic [7:0] instr;
    int         wt;
    logic [3:0] val;
    logic [3:0] a;
    logic [3:0] b;
    logic       sel;
  } vec_t;
  typedef struct {
    logic [1:0] rd;
    logic [3:0] val;
    logic [3:0] pc;
  } exp_t;

  vec_t       tbl [4];
  exp_t       sb [$];
  logic [3:0] m_rf [4];
  logic [3:0] m_pc;
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         t0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_regs();
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      chk($sformatf("rf%0d", i), {4'h0, dbg_data}, {4'h0, m_rf[i]});
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) m_rf[i] = 4'h0;
    m_pc = 4'h0;
    chk("rst_req", {7'h0, imem_req}, 8'h00);
    chk("rst_addr", {4'h0, imem_addr}, 8'h00);
    chk("rst_pc", {4'h0, pc}, 8'h00);
    chk("rst_halted", {7'h0, halted}, 8'h00);
    chk("rst_alu_a", {4'h0, alu_a}, 8'h00);
    chk("rst_alu_b", {4'h0, alu_b}, 8'h00);
    chk("rst_alu_sel", {7'h0, alu_sel}, 8'h00);
    chk_regs();
    rst_n = 1'b1;
    #1;
    chk("idle_req", {7'h0, imem_req}, 8'h00);
    @(negedge clk);
    chk("first_req", {7'h0, imem_req}, 8'h01);
    chk("first_addr", {4'h0, imem_addr}, 8'h00);
  endtask

  task automatic run_vec(input vec_t v);
    int   k;
    exp_t e;
    k = 0;
    while (!imem_req && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("fetch_req", {7'h0, imem_req}, 8'h01);
    chk("fetch_addr", {4'h0, imem_addr}, {4'h0, m_pc});
    for (int w = 0; w < v.wt; w++) begin
      @(negedge clk);
      chk("wait_req", {7'h0, imem_req}, 8'h01);
      chk("wait_addr", {4'h0, imem_addr}, {4'h0, m_pc});
      chk_regs();
    end
    imem_ack = 1'b1;
    imem_data = v.instr;
    sb.push_back('{v.instr[5:4], v.val, 4'(m_pc + 4'h1)});
    @(negedge clk);
    imem_data = 8'hC0;
    chk("exec_req", {7'h0, imem_req}, 8'h00);
    chk("exec_halted", {7'h0, halted}, 8'h00);
    @(negedge clk);
    chk("wb_alu_a", {4'h0, alu_a}, {4'h0, v.a});
    chk("wb_alu_b", {4'h0, alu_b}, {4'h0, v.b});
    chk("wb_alu_sel", {7'h0, alu_sel}, {7'h0, v.sel});
    chk("wb_req", {7'h0, imem_req}, 8'h00);
    @(negedge clk);
    imem_ack = 1'b0;
    e = sb.pop_front();
    m_rf[e.rd] = e.val;
    m_pc = e.pc;
    chk("post_pc", {4'h0, pc}, {4'h0, m_pc});
    chk("post_req", {7'h0, imem_req}, 8'h01);
    chk_regs();
  endtask

  initial begin
    #(50 * 5000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{8'h85, 0, 4'h5, 4'h0, 4'h0, 1'b0};
    tbl[1] = '{8'h9C, 0, 4'hC, 4'h0, 4'h0, 1'b0};
    tbl[2] = '{8'h04, 0, 4'h1, 4'h5, 4'hC, 1'b0};
    tbl[3] = '{8'h50, 3, 4'hF, 4'hC, 4'h1, 1'b1};
    do_reset();
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      run_vec(tbl[i]);
      if (i == 2) chk("elapsed_3_instr", 8'(cyc - t0), 8'd9);
    end
    // HALT at address 4 with acks that must be ignored afterwards
    chk("halt_addr", {4'h0, imem_addr}, 8'h04);
    imem_ack = 1'b1;
    imem_data = 8'hC0;
    @(negedge clk);
    imem_data = 8'h85;
    chk("halt_exec_halted", {7'h0, halted}, 8'h00);
    @(negedge clk);
    chk("halted", {7'h0, halted}, 8'h01);
    chk("halt_req", {7'h0, imem_req}, 8'h00);
    chk("halt_pc", {4'h0, pc}, 8'h04);
    for (int i = 0; i < 20; i++) begin
      imem_ack = ~imem_ack;
      @(negedge clk);
      chk("halt_hold_req", {7'h0, imem_req}, 8'h00);
      chk("halt_hold", {7'h0, halted}, 8'h01);
      chk("halt_hold_pc", {4'h0, pc}, 8'h04);
    end
    imem_ack = 1'b0;
    chk_regs();
    do_reset();
    // 16 LDIs wrap pc back to 0
    for (int i = 0; i < 16; i++) begin
      vec_t v;
      v = '{{2'b10, 2'(i), 4'(i)}, 0, 4'(i), 4'h0, 4'h0, 1'b0};
      run_vec(v);
    end
    chk("wrap_pc", {4'h0, pc}, 8'h00);
    chk("wrap_addr", {4'h0, imem_addr}, 8'h00);
    chk("wrap_req", {7'h0, imem_req}, 8'h01);
    // reset during WB of LDI r2,7 suppresses the write
    imem_ack = 1'b1;
    imem_data = 8'hA7;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) m_rf[i] = 4'h0;
    chk("midwb_pc", {4'h0, pc}, 8'h00);
    chk("midwb_req", {7'h0, imem_req}, 8'h00);
    chk_regs();
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_req", {7'h0, imem_req}, 8'h01);
    chk("restart_addr", {4'h0, imem_addr}, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
